// File: rtl/wb_pipe_reg_pkg.sv
// Shared constants, boundary-action encoding and decode helper for wb_pipe_reg.
// WB_PIPE_DEBUG_PC_EN selects whether the debug PC channel is built.
package wb_pipe_reg_pkg;

   localparam logic Stop      = 1'b1;
   localparam logic NoStop    = 1'b0;
   localparam logic RstActive = 1'b0;

   localparam int unsigned NopRegAddr = 0;
   localparam logic [31:0] ZeroWord   = 32'h0000_0000;

`ifdef WB_PIPE_DEBUG_PC_EN
   localparam bit DebugPcEn = 1'b1;
`else
   localparam bit DebugPcEn = 1'b0;
`endif

   typedef enum logic [1:0] {
      ActAdvance,
      ActHold,
      ActBubble,
      ActFlush
   } wb_act_e;

   // Flush beats any stall; a stalled stage feeding a running one becomes a bubble.
   function automatic wb_act_e decode_act(logic flush, logic stall_cur, logic stall_next);
      if (flush) return ActFlush;
      if (stall_cur == Stop && stall_next == NoStop) return ActBubble;
      if (stall_cur == Stop) return ActHold;
      return ActAdvance;
   endfunction

endpackage

// File: rtl/wb_conflict_squash.sv
// Drops older same-bundle writes to a register that a younger lane also writes.
module wb_conflict_squash #(
   parameter int unsigned NLANES = 2,
   parameter int unsigned ADDR_W = 5
) (
   input  logic [NLANES*ADDR_W-1:0] waddr_i,
   input  logic [NLANES-1:0]        we_i,
   output logic [NLANES-1:0]        we_o
);

   always_comb begin
      we_o = we_i;
      for (int unsigned i = 0; i < NLANES; i++) begin
         for (int unsigned j = i + 1; j < NLANES; j++) begin
            if (we_i[j] && (waddr_i[j*ADDR_W +: ADDR_W] == waddr_i[i*ADDR_W +: ADDR_W])) begin
               we_o[i] = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/wb_pipe_reg.sv
// MEM/WB boundary register: multi-lane writes, HI/LO channel, stall/flush, bubble counter.
// Optional debug PC channel is enabled by defining WB_PIPE_DEBUG_PC_EN.
module wb_pipe_reg
   import wb_pipe_reg_pkg::*;
#(
   parameter int unsigned STAGE   = 4,
   parameter int unsigned STALL_W = 6,
   parameter int unsigned NLANES  = 2,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [STALL_W-1:0]       stall,
   input  logic                     flush,
   input  logic                     mem_valid,
   input  logic [NLANES*ADDR_W-1:0] mem_waddr,
   input  logic [NLANES-1:0]        mem_we,
   input  logic [NLANES*DATA_W-1:0] mem_wdata,
   input  logic                     mem_whilo,
   input  logic [DATA_W-1:0]        mem_hi,
   input  logic [DATA_W-1:0]        mem_lo,
   output logic                     wb_valid,
   output logic [NLANES*ADDR_W-1:0] wb_waddr,
   output logic [NLANES-1:0]        wb_we,
   output logic [NLANES*DATA_W-1:0] wb_wdata,
   output logic                     wb_whilo,
   output logic [DATA_W-1:0]        wb_hi,
   output logic [DATA_W-1:0]        wb_lo,
   output logic [CNT_W-1:0]         bubble_cnt
`ifdef WB_PIPE_DEBUG_PC_EN
   ,
   input  logic [31:0]              debug_pc_i,
   output logic [31:0]              debug_pc_o
`endif
);

   localparam logic [NLANES*ADDR_W-1:0] NopAddrs = {NLANES{ADDR_W'(NopRegAddr)}};

   wb_act_e                   act;
   logic [NLANES-1:0]         we_squashed;

   logic                      valid_q, valid_d;
   logic [NLANES*ADDR_W-1:0]  waddr_q, waddr_d;
   logic [NLANES-1:0]         we_q, we_d;
   logic [NLANES*DATA_W-1:0]  wdata_q, wdata_d;
   logic                      whilo_q, whilo_d;
   logic [DATA_W-1:0]         hi_q, hi_d;
   logic [DATA_W-1:0]         lo_q, lo_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;

   wb_conflict_squash #(
      .NLANES (NLANES),
      .ADDR_W (ADDR_W)
   ) u_squash (
      .waddr_i (mem_waddr),
      .we_i    (mem_we),
      .we_o    (we_squashed)
   );

   assign act = decode_act(flush, stall[STAGE], stall[STAGE+1]);

   always_comb begin
      valid_d = valid_q;
      waddr_d = waddr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      whilo_d = whilo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      unique case (act)
         ActAdvance: begin
            valid_d = mem_valid;
            // An invalid bundle enters write-back as a clean bubble, uncounted.
            waddr_d = mem_valid ? mem_waddr : NopAddrs;
            we_d    = mem_valid ? we_squashed : '0;
            wdata_d = mem_valid ? mem_wdata : '0;
            whilo_d = mem_valid & mem_whilo;
            hi_d    = mem_valid ? mem_hi : '0;
            lo_d    = mem_valid ? mem_lo : '0;
         end
         ActHold: begin
         end
         ActBubble, ActFlush: begin
            valid_d = 1'b0;
            waddr_d = NopAddrs;
            we_d    = '0;
            wdata_d = '0;
            whilo_d = 1'b0;
            hi_d    = '0;
            lo_d    = '0;
            if (act == ActBubble && cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstActive) begin
         valid_q <= 1'b0;
         waddr_q <= NopAddrs;
         we_q    <= '0;
         wdata_q <= '0;
         whilo_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         waddr_q <= waddr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         whilo_q <= whilo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
      end
   end

   assign wb_valid   = valid_q;
   assign wb_waddr   = waddr_q;
   assign wb_we      = we_q;
   assign wb_wdata   = wdata_q;
   assign wb_whilo   = whilo_q;
   assign wb_hi      = hi_q;
   assign wb_lo      = lo_q;
   assign bubble_cnt = cnt_q;

`ifdef WB_PIPE_DEBUG_PC_EN
   logic [31:0] pc_q, pc_d;

   // The PC tracks the slot even for invalid bundles, unlike the data fields.
   always_comb begin
      pc_d = pc_q;
      unique case (act)
         ActAdvance:          pc_d = debug_pc_i;
         ActHold:             pc_d = pc_q;
         ActBubble, ActFlush: pc_d = ZeroWord;
         default:             pc_d = pc_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstActive) begin
         pc_q <= ZeroWord;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign debug_pc_o = (DebugPcEn) ? pc_q : ZeroWord;
`endif

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Self-checking bench for wb_pipe_reg: directed scenarios then randomized traffic
// against a behavioural model; a second instance with a 2-bit counter checks saturation.
module tb_wb_pipe_reg;

   localparam int unsigned STAGE   = 3;
   localparam int unsigned STALL_W = 6;
   localparam int unsigned NLANES  = 2;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CNT_W   = 16;

   logic                     clk;
   logic                     rst;
   logic [STALL_W-1:0]       stall;
   logic                     flush;
   logic                     mem_valid;
   logic [NLANES*ADDR_W-1:0] mem_waddr;
   logic [NLANES-1:0]        mem_we;
   logic [NLANES*DATA_W-1:0] mem_wdata;
   logic                     mem_whilo;
   logic [DATA_W-1:0]        mem_hi;
   logic [DATA_W-1:0]        mem_lo;

   logic                     wb_valid;
   logic [NLANES*ADDR_W-1:0] wb_waddr;
   logic [NLANES-1:0]        wb_we;
   logic [NLANES*DATA_W-1:0] wb_wdata;
   logic                     wb_whilo;
   logic [DATA_W-1:0]        wb_hi;
   logic [DATA_W-1:0]        wb_lo;
   logic [CNT_W-1:0]         bubble_cnt;

   logic                     s_valid;
   logic [NLANES*ADDR_W-1:0] s_waddr;
   logic [NLANES-1:0]        s_we;
   logic [NLANES*DATA_W-1:0] s_wdata;
   logic                     s_whilo;
   logic [DATA_W-1:0]        s_hi;
   logic [DATA_W-1:0]        s_lo;
   logic [1:0]               s_cnt;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the write-back slot.
   logic              m_valid;
   logic [ADDR_W-1:0] m_addr [NLANES];
   logic              m_we   [NLANES];
   logic [DATA_W-1:0] m_data [NLANES];
   logic              m_whilo;
   logic [DATA_W-1:0] m_hi, m_lo;
   int                m_cnt, m_cnt_sat;

   wb_pipe_reg #(
      .STAGE(STAGE), .STALL_W(STALL_W), .NLANES(NLANES),
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
      .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_we(wb_we), .wb_wdata(wb_wdata),
      .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo), .bubble_cnt(bubble_cnt)
   );

   wb_pipe_reg #(
      .STAGE(STAGE), .STALL_W(STALL_W), .NLANES(NLANES),
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(2)
   ) dut_sat (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
      .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .wb_valid(s_valid), .wb_waddr(s_waddr), .wb_we(s_we), .wb_wdata(s_wdata),
      .wb_whilo(s_whilo), .wb_hi(s_hi), .wb_lo(s_lo), .bubble_cnt(s_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_valid = 1'b0;
      m_whilo = 1'b0;
      m_hi    = '0;
      m_lo    = '0;
      for (int i = 0; i < NLANES; i++) begin
         m_addr[i] = '0;
         m_we[i]   = 1'b0;
         m_data[i] = '0;
      end
   endtask

   task automatic model_reset();
      model_clear();
      m_cnt     = 0;
      m_cnt_sat = 0;
   endtask

   // Next-state of the slot from the rules, using the inputs present before the edge.
   task automatic model_step();
      bit claimed [1 << ADDR_W];
      if (rst == 1'b0) begin
         model_reset();
      end else if (flush) begin
         model_clear();
      end else if (stall[STAGE] && !stall[STAGE+1]) begin
         model_clear();
         m_cnt     = (m_cnt == 65535) ? 65535 : m_cnt + 1;
         m_cnt_sat = (m_cnt_sat == 3) ? 3 : m_cnt_sat + 1;
      end else if (stall[STAGE]) begin
         // hold
      end else if (!mem_valid) begin
         model_clear();
      end else begin
         m_valid = 1'b1;
         m_whilo = mem_whilo;
         m_hi    = mem_hi;
         m_lo    = mem_lo;
         for (int a = 0; a < (1 << ADDR_W); a++) claimed[a] = 1'b0;
         // Walk youngest to oldest: an address already claimed squashes older writers.
         for (int i = NLANES - 1; i >= 0; i--) begin
            m_addr[i] = mem_waddr[i*ADDR_W +: ADDR_W];
            m_data[i] = mem_wdata[i*DATA_W +: DATA_W];
            m_we[i]   = mem_we[i] && !claimed[m_addr[i]];
            if (mem_we[i]) claimed[m_addr[i]] = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [NLANES*ADDR_W-1:0] ea;
      logic [NLANES-1:0]        ew;
      logic [NLANES*DATA_W-1:0] ed;
      for (int i = 0; i < NLANES; i++) begin
         ea[i*ADDR_W +: ADDR_W] = m_addr[i];
         ew[i]                  = m_we[i];
         ed[i*DATA_W +: DATA_W] = m_data[i];
      end
      chk({tag, ".valid"}, 128'(wb_valid), 128'(m_valid));
      chk({tag, ".waddr"}, 128'(wb_waddr), 128'(ea));
      chk({tag, ".we"},    128'(wb_we),    128'(ew));
      chk({tag, ".wdata"}, 128'(wb_wdata), 128'(ed));
      chk({tag, ".whilo"}, 128'(wb_whilo), 128'(m_whilo));
      chk({tag, ".hi"},    128'(wb_hi),    128'(m_hi));
      chk({tag, ".lo"},    128'(wb_lo),    128'(m_lo));
      chk({tag, ".cnt"},   128'(bubble_cnt), 128'(m_cnt));
      chk({tag, ".cnt2"},  128'(s_cnt),    128'(m_cnt_sat));
      chk({tag, ".we2"},   128'(s_we),     128'(ew));
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic [STALL_W-1:0] st, input logic fl, input logic v,
                        input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                        input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                        input logic [1:0] we, input logic hl);
      stall     = st;
      flush     = fl;
      mem_valid = v;
      mem_waddr = {a1, a0};
      mem_wdata = {d1, d0};
      mem_we    = we;
      mem_whilo = hl;
      mem_hi    = 32'hA;
      mem_lo    = 32'hB;
   endtask

   initial begin
      int sat_seq [5];
      logic [STALL_W-1:0] st;
      sat_seq = '{1, 2, 3, 3, 3};

      rst = 1'b0;
      drive(6'b000000, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 1'b0);
      model_reset();
      #3;
      check_all("reset_initial");
      @(negedge clk);
      rst = 1'b1;

      // Build wb_we=11 and bubble_cnt=7, then reset between edges.
      drive(6'b001111, 1'b0, 1'b1, 5'd1, 32'h5, 5'd2, 32'h6, 2'b11, 1'b1);
      for (int k = 0; k < 7; k++) cycle("prebubble");
      drive(6'b000000, 1'b0, 1'b1, 5'd1, 32'h5, 5'd2, 32'h6, 2'b11, 1'b1);
      cycle("preload");
      chk("preload_we", 128'(wb_we), 128'(2'b11));
      chk("preload_cnt", 128'(bubble_cnt), 128'(7));
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check_all("reset_mid");
      @(negedge clk);
      rst = 1'b1;
      drive(6'b011111, 1'b0, 1'b1, 5'd9, 32'h99, 5'd10, 32'h98, 2'b11, 1'b1);
      cycle("post_reset_hold0");
      cycle("post_reset_hold1");
      chk("post_reset_valid", 128'(wb_valid), 128'(0));

      // Plain advance.
      drive(6'b000000, 1'b0, 1'b1, 5'd3, 32'h11, 5'd4, 32'h22, 2'b11, 1'b1);
      cycle("advance");
      chk("adv_waddr", 128'(wb_waddr), 128'({5'd4, 5'd3}));
      chk("adv_we", 128'(wb_we), 128'(2'b11));
      chk("adv_wdata", 128'(wb_wdata), 128'({32'h22, 32'h11}));
      chk("adv_hilo", 128'({wb_whilo, wb_hi, wb_lo}), 128'({1'b1, 32'hA, 32'hB}));

      // Hold for three cycles with changing inputs, then a bubble.
      drive(6'b011111, 1'b0, 1'b1, 5'd8, 32'h77, 5'd8, 32'h78, 2'b01, 1'b0);
      for (int k = 0; k < 3; k++) cycle("hold");
      chk("hold_wdata", 128'(wb_wdata), 128'({32'h22, 32'h11}));
      chk("hold_cnt", 128'(bubble_cnt), 128'(0));
      drive(6'b001111, 1'b0, 1'b1, 5'd8, 32'h77, 5'd8, 32'h78, 2'b01, 1'b0);
      cycle("bubble");
      chk("bubble_valid", 128'(wb_valid), 128'(0));
      chk("bubble_cnt", 128'(bubble_cnt), 128'(1));

      // Flush overrides a hold.
      drive(6'b000000, 1'b0, 1'b1, 5'd3, 32'h11, 5'd4, 32'h22, 2'b11, 1'b1);
      cycle("reload");
      drive(6'b011111, 1'b1, 1'b1, 5'd3, 32'h11, 5'd4, 32'h22, 2'b11, 1'b1);
      cycle("flush");
      chk("flush_we", 128'(wb_we), 128'(0));
      chk("flush_cnt", 128'(bubble_cnt), 128'(1));

      // Both lanes write r7: youngest wins.
      drive(6'b000000, 1'b0, 1'b1, 5'd7, 32'h1, 5'd7, 32'h2, 2'b11, 1'b0);
      cycle("conflict");
      chk("conflict_we", 128'(wb_we), 128'(2'b10));
      chk("conflict_d1", 128'(wb_wdata[63:32]), 128'(32'h2));

      // Saturation on the 2-bit instance.
      #2;
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(6'b001111, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 1'b0);
      for (int k = 0; k < 5; k++) begin
         cycle("sat");
         chk("sat_seq", 128'(s_cnt), 128'(sat_seq[k]));
      end

      // Randomized traffic over legal stall patterns.
      for (int k = 0; k < 400; k++) begin
         st = STALL_W'($urandom);
         if (!st[STAGE]) st[STAGE+1] = 1'b0;
         drive(st, ($urandom_range(0, 15) == 0), 1'($urandom),
               5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
               2'($urandom), 1'($urandom));
         mem_hi = $urandom;
         mem_lo = $urandom;
         cycle("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
